// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared control-path constants: register addressing, issue FSM
//            state encoding and major opcodes used by decode.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam int               REG_AW   = 5;
    localparam int               NUM_REGS = 1 << REG_AW;
    localparam logic [REG_AW-1:0] X0      = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Opcodes that redirect the fetch stream and therefore raise flush.
    function automatic logic is_redirect(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter
// Purpose  : One per-register pending-write counter; saturating up/down,
//            simultaneous inc and dec leave the count unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter
    import rv_ctrl_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nz
);

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign nz    = (count_q != '0);

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : Register-read issue/stall controller with a per-register RAW
//            scoreboard and flush-with-drain. Optional macro WB_BYPASS_EN lets
//            a source retiring this cycle (last pending write) skip the stall.
// Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard
    import rv_ctrl_pkg::*;
#(
    parameter int PEND_W       = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              wr_rd,
    output logic              iss_valid,
    input  logic              ex_ready,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              flush,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_INFLIGHT);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0]   pend [NUM_REGS];
    logic [NUM_REGS-1:0] pend_nz;
    logic [NUM_REGS-1:1] pend_inc;
    logic [NUM_REGS-1:1] pend_dec;

    logic src1_pend, src2_pend, hazard, full, sat;
    logic accept, rd_wr, wb_hit;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              iss_valid_q, iss_valid_d;
    logic              busy_q, busy_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    // x0 has no counter: it reads as never pending.
    assign pend[0]    = '0;
    assign pend_nz[0] = 1'b0;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
            assign pend_inc[g] = rd_wr  && (rd == REG_AW'(g));
            assign pend_dec[g] = wb_hit && (wb_addr == REG_AW'(g));

            sb_counter #(
                .PEND_W (PEND_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (pend_inc[g]),
                .dec   (pend_dec[g]),
                .count (pend[g]),
                .nz    (pend_nz[g])
            );
        end
    endgenerate

    always_comb begin
        src1_pend = use_rs1 && (rs1 != X0) && pend_nz[rs1];
        src2_pend = use_rs2 && (rs2 != X0) && pend_nz[rs2];
`ifdef WB_BYPASS_EN
        // The retiring value is forwarded by the register bank, so only the last writer may be bypassed.
        if (wb_valid && (wb_addr == rs1) && (pend[rs1] == PEND_ONE)) src1_pend = 1'b0;
        if (wb_valid && (wb_addr == rs2) && (pend[rs2] == PEND_ONE)) src2_pend = 1'b0;
`endif
        hazard    = src1_pend || src2_pend;
        full      = (inflight_q == MAX_CNT) && wr_rd;
        sat       = wr_rd && (rd != X0) && (pend[rd] == '1);
        dec_ready = (state_q == ST_RUN) && !flush && !hazard && !full && !sat
                    && (!iss_valid_q || ex_ready);
        accept    = dec_valid && dec_ready;
        rd_wr     = accept && wr_rd && (rd != X0);
        wb_hit    = wb_valid && (wb_addr != X0) && pend_nz[wb_addr];
    end

    always_comb begin
        inflight_d = inflight_q;
        if (rd_wr && !wb_hit) begin
            inflight_d = inflight_q + 1'b1;
        end else if (wb_hit && !rd_wr) begin
            inflight_d = inflight_q - 1'b1;
        end

        iss_valid_d = iss_valid_q;
        if (flush) begin
            iss_valid_d = 1'b0;
        end else if (accept) begin
            iss_valid_d = 1'b1;
        end else if (iss_valid_q && ex_ready) begin
            iss_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && dec_valid && !dec_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (flush) state_d = ST_DRAIN;
        end else begin
            if (!flush && (inflight_q == '0)) state_d = ST_RUN;
        end
        busy_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            inflight_q  <= '0;
            iss_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            iss_valid_q <= iss_valid_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && wb_valid && (wb_addr != X0) && !pend_nz[wb_addr]) begin
            $error("issue_scoreboard: writeback to x%0d with no pending write", wb_addr);
        end
    end
`endif

    assign iss_valid = iss_valid_q;
    assign busy      = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
